// File: rtl/hex_display_pkg.sv
// Shared constants for the seven-segment display controller: register map,
// CTRL bit positions and the active-high hex-to-segment table.
package hex_display_pkg;

  localparam logic [3:0] ADDR_DECODE = 4'd12;
  localparam logic [3:0] ADDR_BLINK  = 4'd13;
  localparam logic [3:0] ADDR_BRIGHT = 4'd14;
  localparam logic [3:0] ADDR_CTRL   = 4'd15;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_PHASE   = 1;
  localparam int CTRL_RESTART = 2;

  // Entry [n] is the a..g pattern (bit0 = a) for hex digit n, lit = 1.
  localparam logic [15:0][6:0] HEX7SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] hex7seg(input logic [3:0] nibble);
    return HEX7SEG[nibble];
  endfunction

endpackage

// File: rtl/hex_seg_decoder.sv
// Combinational nibble to seven-segment (a..g, active-high) decoder.
module hex_seg_decoder
  import hex_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex7seg(nibble);

endmodule

// File: rtl/hex_display_ctrl.sv
// Avalon-MM slave driving N_DIGITS seven-segment digits with per-digit
// decode/blink, global PWM brightness and enable; registered outputs.
module hex_display_ctrl
  import hex_display_pkg::*;
#(
  parameter int N_DIGITS   = 6,
  parameter int SEG_W      = 8,
  parameter int BLINK_DIV  = 25000000,
  parameter int PWM_W      = 4,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [3:0]                address,
  input  logic                      chipselect,
  input  logic                      read_n,
  input  logic                      write_n,
  input  logic [31:0]               writedata,
  output logic [31:0]               readdata,
  output logic [N_DIGITS*SEG_W-1:0] seg_out
);

  localparam int                 BLINK_W    = $clog2(BLINK_DIV);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam bit                 AL         = (ACTIVE_LOW != 0);
  localparam logic [SEG_W-1:0]   SEG_OFF    = {SEG_W{AL}};

  logic [N_DIGITS-1:0][SEG_W-1:0] digit_q;
  logic [N_DIGITS-1:0]            decode_q;
  logic [N_DIGITS-1:0]            blink_q;
  logic [PWM_W-1:0]               bright_q;
  logic                           en_q;
  logic                           phase_q;
  logic [BLINK_W-1:0]             blink_cnt;
  logic [PWM_W-1:0]               pwm_cnt;
  logic                           lit;
  logic [31:0]                    rd_mux;
  logic [N_DIGITS-1:0][SEG_W-1:0] seg_nxt;

  logic wr_en, rd_en, restart;
  logic unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign rd_en        = chipselect & ~read_n;
  assign restart      = wr_en && (address == ADDR_CTRL) && writedata[CTRL_RESTART];
  assign unused_wdata = ^writedata;

  // Register file
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_q  <= '0;
      decode_q <= '1;
      blink_q  <= '0;
      bright_q <= '1;
      en_q     <= 1'b0;
    end else if (wr_en) begin
      for (int d = 0; d < N_DIGITS; d++)
        if (address == 4'(d)) digit_q[d] <= writedata[SEG_W-1:0];
      case (address)
        ADDR_DECODE: decode_q <= writedata[N_DIGITS-1:0];
        ADDR_BLINK:  blink_q  <= writedata[N_DIGITS-1:0];
        ADDR_BRIGHT: bright_q <= writedata[PWM_W-1:0];
        ADDR_CTRL:   en_q     <= writedata[CTRL_EN];
        default: ;
      endcase
    end
  end

  // Blink timebase; a RESTART write overrides a coincident wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt <= '0;
      phase_q   <= 1'b0;
    end else if (restart) begin
      blink_cnt <= '0;
      phase_q   <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      phase_q   <= ~phase_q;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pwm_cnt <= '0;
    else       pwm_cnt <= pwm_cnt + 1'b1;
  end

  // Full-scale brightness is steady on rather than 15/16 duty.
  assign lit = (&bright_q) | (pwm_cnt < bright_q);

  always_comb begin
    rd_mux = '0;
    for (int d = 0; d < N_DIGITS; d++)
      if (address == 4'(d)) rd_mux = 32'(digit_q[d]);
    case (address)
      ADDR_DECODE: rd_mux = 32'(decode_q);
      ADDR_BLINK:  rd_mux = 32'(blink_q);
      ADDR_BRIGHT: rd_mux = 32'(bright_q);
      ADDR_CTRL: begin
        rd_mux[CTRL_EN]    = en_q;
        rd_mux[CTRL_PHASE] = phase_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      readdata <= '0;
    else if (rd_en) readdata <= rd_mux;
  end

  for (genvar d = 0; d < N_DIGITS; d++) begin : g_digit
    logic [6:0]       dec;
    logic [SEG_W-1:0] pat;

    hex_seg_decoder u_dec (
      .nibble (digit_q[d][3:0]),
      .seg    (dec)
    );

    // Decode replaces only a..g; dp and any extra bits pass through raw.
    always_comb begin
      pat = digit_q[d];
      if (decode_q[d]) pat[6:0] = dec;
      if (!en_q || !lit || (blink_q[d] && phase_q)) pat = '0;
    end

    assign seg_nxt[d] = AL ? ~pat : pat;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) seg_out <= {N_DIGITS{SEG_OFF}};
    else       seg_out <= seg_nxt;
  end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed bench for hex_display_ctrl: register table plus blink, PWM,
// read/write collision and asynchronous reset sequences.
module tb_hex_display_ctrl;

  localparam int N  = 6;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          read_n = 1'b1;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic [N*SW-1:0] seg_out;

  always #5 clk = ~clk;

  hex_display_ctrl #(
    .N_DIGITS(N), .SEG_W(SW), .BLINK_DIV(4), .PWM_W(4), .ACTIVE_LOW(1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .read_n     (read_n),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .seg_out    (seg_out)
  );

  typedef struct {
    bit          wr;
    logic [3:0]  addr;
    logic [31:0] data;     // write data, or expected readdata for a read
    bit          chk_seg;
    logic [47:0] seg;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic add(input bit wr, input int a, input logic [31:0] d,
                     input bit cs, input logic [47:0] s);
    vec_t v;
    v.wr = wr; v.addr = 4'(a); v.data = d; v.chk_seg = cs; v.seg = s;
    tbl.push_back(v);
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; read_n = 1'b0; address = a;
    @(negedge clk);
    chipselect = 1'b0; read_n = 1'b1;
    d = readdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int          lit_cnt, dark_cnt;
    logic [7:0]  exp_b;
    int          bright_v[4] = '{4, 0, 15, 1};
    int          bright_e[4] = '{4, 0, 16, 1};

    repeat (2) @(negedge clk);
    check("rst_seg", seg_out, 48'hFFFF_FFFF_FFFF);
    check("rst_rdata", readdata, 48'h0);
    reset = 1'b0;

    for (int a = 0; a < 12; a++) add(0, a, 32'h0, 0, 48'h0);
    add(0, 12, 32'h3F, 0, 48'h0);
    add(0, 13, 32'h0,  0, 48'h0);
    add(0, 14, 32'hF,  0, 48'h0);
    add(1, 15, 32'h4,  0, 48'h0);                 // restart only, EN stays 0
    add(0, 15, 32'h0,  0, 48'h0);
    add(1, 15, 32'h1,  1, 48'hC0C0_C0C0_C0C0);
    add(1, 0,  32'h0A, 1, 48'hC0C0_C0C0_C088);
    add(1, 12, 32'h0,  1, 48'hFFFF_FFFF_FFF5);
    add(1, 1,  32'hC3, 1, 48'hFFFF_FFFF_3CF5);
    add(0, 1,  32'hC3, 0, 48'h0);
    add(1, 12, 32'h3F, 1, 48'hC0C0_C0C0_3088);
    add(1, 2,  32'h85, 1, 48'hC0C0_C012_3088);
    add(1, 6,  32'hFF, 1, 48'hC0C0_C012_3088);    // unmapped write ignored
    add(0, 6,  32'h0,  0, 48'h0);
    add(0, 2,  32'h85, 0, 48'h0);
    add(1, 13, 32'hFFFF_FFC0, 1, 48'hC0C0_C012_3088);
    add(0, 13, 32'h0,  0, 48'h0);
    add(1, 14, 32'h1F, 1, 48'hC0C0_C012_3088);
    add(0, 14, 32'hF,  0, 48'h0);
    add(1, 5,  32'h1FF, 1, 48'h0EC0_C012_3088);
    add(0, 5,  32'hFF, 0, 48'h0);
    add(0, 11, 32'h0,  0, 48'h0);
    add(0, 12, 32'h3F, 0, 48'h0);

    foreach (tbl[i]) begin
      if (tbl[i].wr) begin
        bus_wr(tbl[i].addr, tbl[i].data);
        if (tbl[i].chk_seg) begin
          @(negedge clk);
          check($sformatf("v%0d_seg_a%0d", i, tbl[i].addr), seg_out, tbl[i].seg);
        end
      end else begin
        bus_rd(tbl[i].addr, rd);
        check($sformatf("v%0d_rd_a%0d", i, tbl[i].addr), rd, tbl[i].data);
      end
    end

    // Read and write of the same register in one cycle returns the old value.
    @(negedge clk);
    chipselect = 1'b1; read_n = 1'b0; write_n = 1'b0; address = 4'd2; writedata = 32'h55;
    @(negedge clk);
    chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
    check("rw_old", readdata, 48'h85);
    bus_rd(4'd2, rd);
    check("rw_new", rd, 48'h55);

    // Blink digit 0 only; restart at edge k, then phase after edge k+j is (j/4)&1.
    bus_wr(4'd13, 32'h1);
    bus_wr(4'd15, 32'h5);
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      exp_b = (((j - 1) / 4) % 2 != 0) ? 8'hFF : 8'h88;
      check($sformatf("blink_d0_%0d", j), seg_out[7:0], exp_b);
      check($sformatf("blink_d1_%0d", j), seg_out[15:8], 8'h30);
    end
    // Restart accepted on edge k+12, where the counter would wrap and set PHASE.
    repeat (2) @(negedge clk);
    bus_wr(4'd15, 32'h5);
    bus_rd(4'd15, rd);
    check("restart_on_wrap", rd, 48'h1);

    // PWM duty over one full 16-cycle period.
    bus_wr(4'd13, 32'h0);
    for (int b = 0; b < 4; b++) begin
      bus_wr(4'd14, 32'(bright_v[b]));
      lit_cnt = 0; dark_cnt = 0;
      for (int j = 0; j < 16; j++) begin
        @(negedge clk);
        if (seg_out[7:0] == 8'h88) lit_cnt++;
        else if (seg_out[7:0] == 8'hFF) dark_cnt++;
      end
      check($sformatf("pwm_lit_b%0d", bright_v[b]), 48'(lit_cnt), 48'(bright_e[b]));
      check($sformatf("pwm_dark_b%0d", bright_v[b]), 48'(dark_cnt), 48'(16 - bright_e[b]));
    end

    // Asynchronous reset in the middle of blinking.
    bus_wr(4'd13, 32'h1);
    bus_wr(4'd15, 32'h5);
    bus_rd(4'd5, rd);
    check("pre_rst_rd", rd, 48'hFF);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_seg", seg_out, 48'hFFFF_FFFF_FFFF);
    check("async_rst_rdata", readdata, 48'h0);
    @(negedge clk);
    reset = 1'b0;
    bus_rd(4'd0, rd);  check("post_rst_d0", rd, 48'h0);
    bus_rd(4'd12, rd); check("post_rst_dec", rd, 48'h3F);
    bus_rd(4'd13, rd); check("post_rst_blink", rd, 48'h0);
    bus_rd(4'd14, rd); check("post_rst_bright", rd, 48'hF);
    bus_rd(4'd15, rd); check("post_rst_ctrl", rd, 48'h0);
    check("post_rst_seg", seg_out, 48'hFFFF_FFFF_FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
